uart_rx: RTL and testbench

UART receiver: the receive-side counterpart of uart_tx, sharing its frame format (1 start bit low, WordSize data bits LSB first, 1 stop bit high, no parity). It samples the asynchronous serial line, recovers each word, and presents it on a valid/ack handshake toward the consumer. It sits between the board RX pin and the on-chip command/data path.

---
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style frame (start low, WordSize data bits LSB first,
// one stop bit high, no parity). Oversamples the line with a baud counter,
// centres on each bit, and hands complete words to the consumer on a
// valid/ack handshake. Reception never stalls on the handshake; a word that
// completes while the previous one is still unaccepted is dropped.
module uart_rx #(
    parameter int unsigned ClkRate  = 100_000_000,
    parameter int unsigned BaudRate = 115200,
    parameter int unsigned WordSize = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                uart_i,
    output logic [WordSize-1:0] data_o,
    output logic                data_valid_o,
    input  logic                data_ack_i,
    output logic                frame_error_o,
    output logic                overrun_o
);

    localparam int unsigned BaudDiv = ClkRate / BaudRate;
    localparam int unsigned HalfDiv = BaudDiv / 2;
    localparam int unsigned CntW    = $clog2(BaudDiv);
    localparam int unsigned IdxW    = (WordSize > 1) ? $clog2(WordSize) : 1;

    // Fewer than four clocks per bit leaves no room to centre the samples.
    if (BaudDiv < 4) begin : g_baud_check
        $error("uart_rx: ClkRate/BaudRate must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic                r_sync1;
    logic                r_sync2;
    logic                w_rx_s;
    state_t              r_state;
    state_t              w_state_next;
    logic [CntW-1:0]     r_cnt;
    logic [IdxW-1:0]     r_idx;
    logic [WordSize-1:0] r_shift;
    logic                r_done;
    logic [WordSize-1:0] r_data;
    logic                r_valid;
    logic                r_frame_error;
    logic                r_overrun;

    logic                w_tick_half;
    logic                w_tick_full;
    logic                w_cnt_clear;
    logic                w_idx_clear;
    logic                w_idx_inc;
    logic                w_sample_bit;
    logic                w_done;
    logic                w_ferr;

    assign w_rx_s      = r_sync2;
    assign w_tick_half = (r_cnt == CntW'(HalfDiv - 1));
    assign w_tick_full = (r_cnt == CntW'(BaudDiv - 1));

    assign data_o        = r_data;
    assign data_valid_o  = r_valid;
    assign frame_error_o = r_frame_error;
    assign overrun_o     = r_overrun;

    // Two-flop synchroniser for the asynchronous line; resets to idle-high.
    // NOTE: clocked state always uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_i;
            r_sync2 <= r_sync1;
        end
    end

    // Frame state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control decoded from state and baud ticks.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clear  = 1'b0;
        w_idx_clear  = 1'b0;
        w_idx_inc    = 1'b0;
        w_sample_bit = 1'b0;
        w_done       = 1'b0;
        w_ferr       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_clear = 1'b1;
                if (!w_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tick_half) begin
                    w_cnt_clear = 1'b1;
                    if (!w_rx_s) begin
                        w_idx_clear  = 1'b1;
                        w_state_next = S_DATA;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick_full) begin
                    w_cnt_clear  = 1'b1;
                    w_sample_bit = 1'b1;
                    if (r_idx == IdxW'(WordSize - 1)) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick_full) begin
                    w_cnt_clear = 1'b1;
                    if (w_rx_s) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_clear = 1'b1;
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Baud counter, bit index and LSB-first shift register.
    // NOTE: the shift register is a plain vector of flops, so it is reset
    // along with the counters; nothing here maps to a RAM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shift       <= '0;
            r_done        <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clear ? '0 : r_cnt + CntW'(1);
            if (w_idx_clear) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IdxW'(1);
            end
            if (w_sample_bit) begin
                r_shift[r_idx] <= w_rx_s;
            end
            r_done        <= w_done;
            r_frame_error <= w_ferr;
        end
    end

    // Output handshake: load on completion unless the old word is still
    // pending and unacknowledged, in which case flag an overrun instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_valid || data_ack_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && data_ack_i) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. The baud rate is raised so that BaudDiv is 16,
// keeping the full 256-word loopback short; all bit timing scales with it.
module tb_uart_rx;

    localparam int unsigned ClkRate  = 100_000_000;
    localparam int unsigned BaudRate = 6_250_000;
    localparam int unsigned WordSize = 8;
    localparam int          BD       = ClkRate / BaudRate;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       uart_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       data_ack_i;
    logic       frame_error_o;
    logic       overrun_o;

    int         checks = 0;
    int         failures = 0;

    // 0: ack tied high, 1: ack 3 cycles after valid, 2: ack follows man_ack
    int         ack_mode = 2;
    logic       man_ack = 1'b0;
    logic [7:0] rx_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         viol_x = 0;
    int         viol_pulse = 0;
    int         viol_stable = 0;

    always #5 clk_i = ~clk_i;

    uart_rx #(
        .ClkRate (ClkRate),
        .BaudRate(BaudRate),
        .WordSize(WordSize)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .uart_i       (uart_i),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_ack_i   (data_ack_i),
        .frame_error_o(frame_error_o),
        .overrun_o    (overrun_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Drives one frame; the line is left at the stop-bit level afterwards.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_i = 1'b0;
        idle(BD);
        for (int i = 0; i < 8; i++) begin
            uart_i = b[i];
            idle(BD);
        end
        uart_i = stop_bit;
        idle(BD);
    endtask

    task automatic clear_log();
        rx_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    function automatic logic [7:0] q_at(input int i);
        return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
    endfunction

    // Consumer model and protocol monitor, evaluated mid-cycle.
    initial begin
        int         age;
        logic       prev_fe;
        logic       prev_ov;
        logic       prev_valid;
        logic       prev_xfer;
        logic [7:0] prev_data;
        age        = 0;
        prev_fe    = 1'b0;
        prev_ov    = 1'b0;
        prev_valid = 1'b0;
        prev_xfer  = 1'b0;
        prev_data  = '0;
        data_ack_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_ni !== 1'b1) begin
                age        = 0;
                prev_fe    = 1'b0;
                prev_ov    = 1'b0;
                prev_valid = 1'b0;
                prev_xfer  = 1'b0;
            end else begin
                if ($isunknown({data_o, data_valid_o, frame_error_o, overrun_o})) viol_x++;
                if (frame_error_o && prev_fe) viol_pulse++;
                if (overrun_o && prev_ov) viol_pulse++;
                fe_cnt += int'(frame_error_o);
                ov_cnt += int'(overrun_o);
                if (prev_valid && data_valid_o && !prev_xfer && data_o !== prev_data) viol_stable++;
                age = data_valid_o ? age + 1 : 0;
                case (ack_mode)
                    0:       data_ack_i = 1'b1;
                    1:       data_ack_i = data_valid_o && (age >= 3);
                    default: data_ack_i = man_ack;
                endcase
                prev_xfer = data_valid_o && data_ack_i;
                if (prev_xfer) rx_q.push_back(data_o);
                prev_fe    = frame_error_o;
                prev_ov    = overrun_o;
                prev_valid = data_valid_o;
                prev_data  = data_o;
            end
        end
    end

    initial begin
        logic [7:0] exp4[4];
        logic [7:0] part;
        exp4 = '{8'h00, 8'hFF, 8'h55, 8'hA5};
        part = 8'hC3;

        // Reset state.
        rst_ni = 1'b0;
        uart_i = 1'b1;
        idle(5);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(data_valid_o), 32'h0);
        check("rst_ferr", 32'(frame_error_o), 32'h0);
        check("rst_ovr", 32'(overrun_o), 32'h0);
        rst_ni = 1'b1;
        idle(2 * BD);

        // Single word, ack tied high.
        ack_mode = 0;
        clear_log();
        send_byte(8'hAB, 1'b1);
        idle(2 * BD);
        check("ab_count", 32'(rx_q.size()), 32'd1);
        check("ab_data", 32'(q_at(0)), 32'hAB);
        check("ab_ferr", 32'(fe_cnt), 32'd0);
        check("ab_ovr", 32'(ov_cnt), 32'd0);

        // Back-to-back frames, ack three cycles after valid.
        ack_mode = 1;
        clear_log();
        for (int i = 0; i < 4; i++) send_byte(exp4[i], 1'b1);
        idle(2 * BD);
        check("b2b_count", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("b2b_data", 32'(q_at(i)), 32'(exp4[i]));
        check("b2b_ovr", 32'(ov_cnt), 32'd0);

        // Overrun: ack held low across two words.
        ack_mode = 2;
        man_ack  = 1'b0;
        clear_log();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(2 * BD);
        check("ovr_valid", 32'(data_valid_o), 32'h1);
        check("ovr_data_held", 32'(data_o), 32'h12);
        check("ovr_pulses", 32'(ov_cnt), 32'd1);
        check("ovr_no_xfer", 32'(rx_q.size()), 32'd0);
        @(posedge clk_i);
        man_ack = 1'b1;
        @(posedge clk_i);
        man_ack = 1'b0;
        idle(2 * BD);
        check("ovr_valid_after_ack", 32'(data_valid_o), 32'h0);
        check("ovr_xfer_count", 32'(rx_q.size()), 32'd1);
        check("ovr_xfer_data", 32'(q_at(0)), 32'h12);
        check("ovr_pulses_final", 32'(ov_cnt), 32'd1);

        // Low stop bit, break held three bit times, then a clean frame.
        ack_mode = 0;
        clear_log();
        send_byte(8'h3C, 1'b0);
        idle(3 * BD);
        uart_i = 1'b1;
        idle(BD);
        send_byte(8'h77, 1'b1);
        idle(2 * BD);
        check("ferr_pulses", 32'(fe_cnt), 32'd1);
        check("ferr_count", 32'(rx_q.size()), 32'd1);
        check("ferr_next_data", 32'(q_at(0)), 32'h77);
        check("ferr_ovr", 32'(ov_cnt), 32'd0);

        // Short low glitch on an idle line is rejected.
        clear_log();
        uart_i = 1'b0;
        idle(5);
        uart_i = 1'b1;
        idle(2 * BD);
        check("glitch_count", 32'(rx_q.size()), 32'd0);
        check("glitch_ferr", 32'(fe_cnt), 32'd0);
        send_byte(8'h9E, 1'b1);
        idle(2 * BD);
        check("glitch_next_count", 32'(rx_q.size()), 32'd1);
        check("glitch_next_data", 32'(q_at(0)), 32'h9E);

        // Asynchronous reset mid-frame with a word still pending.
        ack_mode = 2;
        man_ack  = 1'b0;
        clear_log();
        send_byte(8'h81, 1'b1);
        idle(2 * BD);
        check("pre_rst_valid", 32'(data_valid_o), 32'h1);
        check("pre_rst_data", 32'(data_o), 32'h81);
        uart_i = 1'b0;
        idle(BD);
        for (int i = 0; i < 4; i++) begin
            uart_i = part[i];
            idle(BD);
        end
        #2 rst_ni = 1'b0;
        #1;
        check("arst_data", 32'(data_o), 32'h0);
        check("arst_valid", 32'(data_valid_o), 32'h0);
        check("arst_ferr", 32'(frame_error_o), 32'h0);
        check("arst_ovr", 32'(overrun_o), 32'h0);
        uart_i = 1'b1;
        idle(3);
        rst_ni = 1'b1;
        idle(2 * BD);
        ack_mode = 0;
        clear_log();
        send_byte(8'h5A, 1'b1);
        idle(2 * BD);
        check("post_rst_count", 32'(rx_q.size()), 32'd1);
        check("post_rst_data", 32'(q_at(0)), 32'h5A);
        check("post_rst_ferr", 32'(fe_cnt), 32'd0);

        // Loopback of every byte value.
        clear_log();
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
        idle(2 * BD);
        check("loop_count", 32'(rx_q.size()), 32'd256);
        for (int i = 0; i < rx_q.size(); i++) check("loop_data", 32'(rx_q[i]), 32'(i));
        check("loop_ferr", 32'(fe_cnt), 32'd0);
        check("loop_ovr", 32'(ov_cnt), 32'd0);

        // Protocol invariants gathered over the whole run.
        check("never_x", 32'(viol_x), 32'd0);
        check("single_cycle_pulses", 32'(viol_pulse), 32'd0);
        check("data_stable_while_valid", 32'(viol_stable), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
